occ_rom_arbiter: RTL and testbench

- Shares the single Occ ROM read port (ce/addr in, data/valid out) between NUM_REQ requesters, e.g. the two Occ-fetch stages of the accelerator pipeline.
- Round-robin arbitration, one outstanding ROM read at a time.
- Routes the returned word and a per-requester response pulse back to the winner.
- Replaces static state-based muxing of ce/addr/valid, so both fetch stages can issue without a global state decode.

---
 rtl/occ_rom_arbiter_pkg.sv | 13 +
 rtl/occ_rom_arbiter_if.sv | 27 ++
 rtl/occ_rom_arbiter_rr_pick.sv | 29 ++
 rtl/occ_rom_arbiter.sv | 142 ++++++++++++++
 tb/tb_occ_rom_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/occ_rom_arbiter_pkg.sv
// rtl/occ_rom_arbiter_pkg.sv - shared FSM encoding and Occ ROM widths for the Occ ROM arbiter
package occ_rom_arbiter_pkg;

  localparam int OCC_ADDR_W = 8;
  localparam int OCC_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b10
  } arb_state_e;

endpackage

// File: rtl/occ_rom_arbiter_if.sv
// rtl/occ_rom_arbiter_if.sv - requester-side request/grant/response bundle of the Occ ROM arbiter
interface occ_rom_arbiter_if
  import occ_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = OCC_ADDR_W,
  parameter int DATA_W  = OCC_DATA_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;

  modport master (
    output req, req_addr,
    input  gnt, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req, req_addr,
    output gnt, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/occ_rom_arbiter_rr_pick.sv
// rtl/occ_rom_arbiter_rr_pick.sv - combinational round-robin priority encoder (first set bit from rr_ptr upward, wrapping)
module occ_rom_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int pos;

  // Scan from the farthest offset down so the nearest set bit from rr_ptr wins last.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req_i[IDX_W'(pos)]) begin
        idx_o = IDX_W'(pos);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/occ_rom_arbiter.sv
// rtl/occ_rom_arbiter.sv - round-robin sharing of the single Occ ROM read port; OCC_ARB_TIMEOUT_EN adds a WAIT watchdog
module occ_rom_arbiter
  import occ_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = OCC_ADDR_W,
  parameter int DATA_W         = OCC_DATA_W,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  occ_rom_arbiter_if.slave  bus,
  output logic              ce_rom_Occ_o,
  output logic [ADDR_W-1:0] addr_rom_Occ_o,
  input  logic [DATA_W-1:0] data_Occ_i,
  input  logic              data_Occ_valid_i,
  output logic              busy_o
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ce_q, ce_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  pick_addr;
  logic               timeout_hit;

  occ_rom_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    pick_addr = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (pick_idx == IDX_W'(n)) pick_addr = bus.req_addr[n*ADDR_W +: ADDR_W];
    end
  end

`ifdef OCC_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign timeout_hit = (int'(cnt_q) + 1 >= TIMEOUT_CYCLES);
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    ce_d        = ce_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
`ifdef OCC_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          idx_d   = pick_idx;
          addr_d  = pick_addr;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          ce_d    = 1'b1;
          state_d = ARB_ISSUE;
`ifdef OCC_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_ISSUE, ARB_WAIT: begin
        if (state_q == ARB_ISSUE) state_d = ARB_WAIT;
`ifdef OCC_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // A valid arriving on the timeout cycle takes precedence over the error response.
        if (data_Occ_valid_i || timeout_hit) begin
          rsp_valid_d = NUM_REQ'(1) << idx_q;
          rsp_data_d  = data_Occ_valid_i ? data_Occ_i : '0;
          rsp_err_d   = !data_Occ_valid_i;
          ce_d        = 1'b0;
          rr_ptr_d    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      ce_q        <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef OCC_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      ce_q        <= ce_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef OCC_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign ce_rom_Occ_o   = ce_q;
  assign addr_rom_Occ_o = addr_q;
  assign busy_o         = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// tb/tb_occ_rom_arbiter.sv - self-checking bench for occ_rom_arbiter (transaction table plus reset/stray/timeout sequences)
module tb_occ_rom_arbiter;

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [1:0]  req_after;
    int          lat;
    logic [31:0] data;
    logic [1:0]  gnt;
    logic [7:0]  addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [7:0]  addr;
  logic [31:0] data_occ;
  logic        data_occ_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  occ_rom_arbiter_if #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32)) bus ();

  occ_rom_arbiter #(
    .NUM_REQ(2), .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .ce_rom_Occ_o     (ce),
    .addr_rom_Occ_o   (addr),
    .data_Occ_i       (data_occ),
    .data_Occ_valid_i (data_occ_valid),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int waited;
    waited = 0;
    bus.req      = v.req;
    bus.req_addr = {v.a1, v.a0};
    do begin
      @(negedge clk);
      waited++;
    end while (bus.gnt == 2'b00 && waited < 10);
    check("gnt", 32'(bus.gnt), 32'(v.gnt));
    check("gnt_latency", 32'(waited), 32'd1);
    check("ce_on", 32'(ce), 32'd1);
    check("rom_addr", 32'(addr), 32'(v.addr));
    check("busy_on", 32'(busy), 32'd1);
    bus.req = v.req_after;
    for (int i = 0; i < v.lat; i++) begin
      @(negedge clk);
      check("ce_hold", 32'(ce), 32'd1);
      check("addr_hold", 32'(addr), 32'(v.addr));
      check("gnt_pulse", 32'(bus.gnt), 32'd0);
      check("no_early_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    data_occ_valid = 1'b1;
    data_occ       = v.data;
    @(negedge clk);
    data_occ_valid = 1'b0;
    data_occ       = '0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(v.gnt));
    check("rsp_data", bus.rsp_data, v.data);
    check("rsp_err", 32'(bus.rsp_err), 32'd0);
    check("ce_off", 32'(ce), 32'd0);
    check("busy_off", 32'(busy), 32'd0);
  endtask

  vec_t vecs[7];
  vec_t v_after_rst;

  initial begin
    vecs[0] = '{2'b01, 8'h1A, 8'h00, 2'b00, 2, 32'hDEADBEEF, 2'b01, 8'h1A};
    vecs[1] = '{2'b10, 8'h00, 8'h33, 2'b00, 3, 32'h0BADF00D, 2'b10, 8'h33};
    vecs[2] = '{2'b11, 8'h10, 8'h20, 2'b11, 1, 32'hA0000001, 2'b01, 8'h10};
    vecs[3] = '{2'b11, 8'h10, 8'h20, 2'b11, 2, 32'hA0000002, 2'b10, 8'h20};
    vecs[4] = '{2'b11, 8'h10, 8'h20, 2'b00, 1, 32'hA0000003, 2'b01, 8'h10};
    vecs[5] = '{2'b10, 8'h00, 8'h5C, 2'b00, 0, 32'hCAFEF00D, 2'b10, 8'h5C};
    vecs[6] = '{2'b11, 8'h44, 8'h55, 2'b00, 0, 32'h12345678, 2'b01, 8'h44};
    v_after_rst = '{2'b11, 8'h66, 8'h77, 2'b00, 1, 32'h0000ABCD, 2'b01, 8'h66};

    rst_n          = 1'b0;
    bus.req        = '0;
    bus.req_addr   = '0;
    data_occ       = '0;
    data_occ_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_ce", 32'(ce), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Response pulse clears, then a stray valid in IDLE is ignored.
    @(negedge clk);
    check("rsp_pulse_clear", 32'(bus.rsp_valid), 32'd0);
    check("rsp_data_hold", bus.rsp_data, 32'h12345678);
    data_occ_valid = 1'b1;
    data_occ       = 32'hFFFFFFFF;
    @(negedge clk);
    data_occ_valid = 1'b0;
    check("stray_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("stray_rsp_data", bus.rsp_data, 32'h12345678);
    check("stray_busy", 32'(busy), 32'd0);

    // Reset during WAIT abandons the read; a late valid is ignored.
    bus.req      = 2'b01;
    bus.req_addr = {8'h00, 8'h77};
    @(negedge clk);
    check("mid_gnt", 32'(bus.gnt), 32'd1);
    bus.req = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ce", 32'(ce), 32'd0);
    check("mid_rst_addr", 32'(addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp_data", bus.rsp_data, 32'd0);
    check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    rst_n          = 1'b1;
    data_occ_valid = 1'b1;
    data_occ       = 32'h00000099;
    @(negedge clk);
    data_occ_valid = 1'b0;
    check("late_valid_rsp", 32'(bus.rsp_valid), 32'd0);
    check("late_valid_data", bus.rsp_data, 32'd0);
    check("late_valid_busy", 32'(busy), 32'd0);
    run_vec(v_after_rst);

`ifdef OCC_ARB_TIMEOUT_EN
    bus.req      = 2'b11;
    bus.req_addr = {8'h22, 8'h11};
    @(negedge clk);
    check("to_gnt", 32'(bus.gnt), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("to_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check("to_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("to_rsp_valid", 32'(bus.rsp_valid), 32'd2);
    check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("to_rsp_data", bus.rsp_data, 32'd0);
    check("to_ce", 32'(ce), 32'd0);
    @(negedge clk);
    check("to_next_gnt", 32'(bus.gnt), 32'd1);
    bus.req        = 2'b00;
    data_occ_valid = 1'b1;
    data_occ       = 32'h00000005;
    @(negedge clk);
    data_occ_valid = 1'b0;
    check("to_after_rsp", 32'(bus.rsp_valid), 32'd1);
    check("to_after_err", 32'(bus.rsp_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
